// File: rtl/vga_sprite_bounce_module.sv
`timescale 1ns/1ps
// Bouncing square sprite plus one-pixel white border drawn over the VGA active area.
// Latency: 1 clock from Ready/address/sync inputs to RGB and realigned sync outputs.
// Backpressure: none; free-running pixel stream, position updates once per VSYNC fall.
module vga_sprite_bounce_module #(
  parameter int H_ACT  = 800,
  parameter int V_ACT  = 600,
  parameter int SIZE   = 32,
  parameter int STEP   = 4,
  parameter int X_INIT = 100,
  parameter int Y_INIT = 50
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        Move_En,
  input  logic        HSYNC_Sig,
  input  logic        VSYNC_Sig,
  input  logic        Ready_Sig,
  input  logic [10:0] Column_Addr_Sig,
  input  logic [10:0] Row_Addr_Sig,
  output logic        HSYNC_Out,
  output logic        VSYNC_Out,
  output logic        Red_Sig,
  output logic        Green_Sig,
  output logic        Blue_Sig
);

  // Arithmetic is done in 12 bits so Pos+STEP and Pos+SIZE never wrap.
  localparam logic [11:0] X_MAX  = 12'(H_ACT - SIZE);
  localparam logic [11:0] Y_MAX  = 12'(V_ACT - SIZE);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [11:0] SIZE12 = 12'(SIZE);
  localparam logic [10:0] H_LAST = 11'(H_ACT - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACT - 1);

  logic [10:0] r_pos_x, r_pos_y;
  logic        r_dir_x, r_dir_y;
  logic [2:0]  r_color;
  logic        r_vsync_d;
  logic [2:0]  r_rgb;
  logic        r_hsync, r_vsync;

  logic        w_frame_tick;
  logic [11:0] w_x_ext, w_y_ext, w_x_sum, w_y_sum, w_x_dif, w_y_dif;
  logic [10:0] w_x_nxt, w_y_nxt;
  logic        w_x_dir_nxt, w_y_dir_nxt, w_x_bnc, w_y_bnc;
  logic [2:0]  w_color_inc;
  logic [11:0] w_col_ext, w_row_ext;
  logic        w_in_sprite, w_on_border;

  assign w_frame_tick = r_vsync_d & ~VSYNC_Sig;
  assign w_x_ext      = {1'b0, r_pos_x};
  assign w_y_ext      = {1'b0, r_pos_y};
  assign w_x_sum      = w_x_ext + STEP12;
  assign w_y_sum      = w_y_ext + STEP12;
  assign w_x_dif      = w_x_ext - STEP12;
  assign w_y_dif      = w_y_ext - STEP12;
  // Black is reserved for background, so the colour cycle skips 000.
  assign w_color_inc  = (r_color == 3'b111) ? 3'b001 : r_color + 3'd1;

  // Horizontal candidate move: clamp to the edge and reverse when the step would reach it.
  always_comb begin
    w_x_nxt     = r_pos_x;
    w_x_dir_nxt = r_dir_x;
    w_x_bnc     = 1'b0;
    if (r_dir_x) begin
      if (w_x_sum >= X_MAX) begin
        w_x_nxt     = X_MAX[10:0];
        w_x_dir_nxt = 1'b0;
        w_x_bnc     = 1'b1;
      end else begin
        w_x_nxt = w_x_sum[10:0];
      end
    end else if (w_x_ext <= STEP12) begin
      w_x_nxt     = 11'd0;
      w_x_dir_nxt = 1'b1;
      w_x_bnc     = 1'b1;
    end else begin
      w_x_nxt = w_x_dif[10:0];
    end
  end

  // Vertical candidate move, same rule against the row limit.
  always_comb begin
    w_y_nxt     = r_pos_y;
    w_y_dir_nxt = r_dir_y;
    w_y_bnc     = 1'b0;
    if (r_dir_y) begin
      if (w_y_sum >= Y_MAX) begin
        w_y_nxt     = Y_MAX[10:0];
        w_y_dir_nxt = 1'b0;
        w_y_bnc     = 1'b1;
      end else begin
        w_y_nxt = w_y_sum[10:0];
      end
    end else if (w_y_ext <= STEP12) begin
      w_y_nxt     = 11'd0;
      w_y_dir_nxt = 1'b1;
      w_y_bnc     = 1'b1;
    end else begin
      w_y_nxt = w_y_dif[10:0];
    end
  end

  assign w_col_ext   = {1'b0, Column_Addr_Sig};
  assign w_row_ext   = {1'b0, Row_Addr_Sig};
  assign w_in_sprite = (w_col_ext >= w_x_ext) && (w_col_ext < w_x_ext + SIZE12) &&
                       (w_row_ext >= w_y_ext) && (w_row_ext < w_y_ext + SIZE12);
  assign w_on_border = (Column_Addr_Sig == 11'd0) || (Column_Addr_Sig == H_LAST) ||
                       (Row_Addr_Sig == 11'd0)    || (Row_Addr_Sig == V_LAST);

  // Sprite state advances only on the VSYNC falling edge, inside vertical blanking.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_pos_x   <= 11'(X_INIT);
      r_pos_y   <= 11'(Y_INIT);
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_color   <= 3'b100;
      r_vsync_d <= 1'b1;
    end else begin
      r_vsync_d <= VSYNC_Sig;
      if (w_frame_tick && Move_En) begin
        r_pos_x <= w_x_nxt;
        r_pos_y <= w_y_nxt;
        r_dir_x <= w_x_dir_nxt;
        r_dir_y <= w_y_dir_nxt;
        // A corner hit counts as a single bounce.
        if (w_x_bnc || w_y_bnc) r_color <= w_color_inc;
      end
    end
  end

  // Registered pixel colour (sprite over border over background) with syncs delayed to match.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_rgb   <= 3'b000;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_hsync <= HSYNC_Sig;
      r_vsync <= VSYNC_Sig;
      if (!Ready_Sig)       r_rgb <= 3'b000;
      else if (w_in_sprite) r_rgb <= r_color;
      else if (w_on_border) r_rgb <= 3'b111;
      else                  r_rgb <= 3'b000;
    end
  end

  assign HSYNC_Out = r_hsync;
  assign VSYNC_Out = r_vsync;
  assign Red_Sig   = r_rgb[2];
  assign Green_Sig = r_rgb[1];
  assign Blue_Sig  = r_rgb[0];

endmodule

// File: tb/tb_vga_sprite_bounce_module.sv
`timescale 1ns/1ps
// Bench for the bouncing-sprite pixel stage: two instances (default start and a near-corner start)
// share one stimulus stream; a position/colour model predicts every probed pixel one clock later.
// Frame ticks are VSYNC falls with random hold lengths and random Move_En gating.
module tb_vga_sprite_bounce_module;
  localparam int H = 800, V = 600, SIZE = 32, STEP = 4;

  logic        vga_clk = 1'b0;
  logic        rst_n, Move_En, HSYNC_Sig, VSYNC_Sig, Ready_Sig;
  logic [10:0] Column_Addr_Sig, Row_Addr_Sig;
  logic [2:0]  rgb0, rgb1;
  logic        hs0, vs0, hs1, vs1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = default instance, 1 = corner instance.
  int mx[2], my[2], mcol[2];
  bit mdx[2], mdy[2];

  always #5 vga_clk = ~vga_clk;

  vga_sprite_bounce_module u_dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .Move_En(Move_En),
    .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
    .HSYNC_Out(hs0), .VSYNC_Out(vs0),
    .Red_Sig(rgb0[2]), .Green_Sig(rgb0[1]), .Blue_Sig(rgb0[0])
  );

  vga_sprite_bounce_module #(.X_INIT(765), .Y_INIT(566)) u_crn (
    .vga_clk(vga_clk), .rst_n(rst_n), .Move_En(Move_En),
    .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
    .HSYNC_Out(hs1), .VSYNC_Out(vs1),
    .Red_Sig(rgb1[2]), .Green_Sig(rgb1[1]), .Blue_Sig(rgb1[0])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mx[0] = 100; my[0] = 50;
    mx[1] = 765; my[1] = 566;
    for (int i = 0; i < 2; i++) begin
      mdx[i] = 1'b1; mdy[i] = 1'b1; mcol[i] = 4;
    end
  endfunction

  // One axis: move STEP toward the current direction, stop at the wall and turn around.
  function automatic void step_axis(input int p_in, input bit d_in, input int lim,
                                    output int p, output bit d, output bit b);
    int tgt;
    tgt = d_in ? p_in + STEP : p_in - STEP;
    if (d_in && tgt >= lim)      begin p = lim; d = 1'b0; b = 1'b1; end
    else if (!d_in && tgt <= 0)  begin p = 0;   d = 1'b1; b = 1'b1; end
    else                         begin p = tgt; d = d_in; b = 1'b0; end
  endfunction

  function automatic void model_tick(input int i);
    int px, py; bit dx, dy, bx, by;
    step_axis(mx[i], mdx[i], H - SIZE, px, dx, bx);
    step_axis(my[i], mdy[i], V - SIZE, py, dy, by);
    mx[i] = px; my[i] = py; mdx[i] = dx; mdy[i] = dy;
    if (bx || by) mcol[i] = (mcol[i] % 7) + 1;
  endfunction

  function automatic logic [2:0] exp_rgb(input int i, input int c, input int r, input bit rdy);
    if (!rdy) return 3'b000;
    if (c >= mx[i] && c < mx[i] + SIZE && r >= my[i] && r < my[i] + SIZE) return 3'(mcol[i]);
    if (c == 0 || c == H - 1 || r == 0 || r == V - 1) return 3'b111;
    return 3'b000;
  endfunction

  // Present one address, then check both instances' pixels and sync realignment one clock later.
  task automatic pix(input int c, input int r, input bit rdy, input string tag);
    logic [2:0] e0, e1;
    logic hs;
    hs = 1'($urandom_range(0, 1));
    Column_Addr_Sig = 11'(c); Row_Addr_Sig = 11'(r); Ready_Sig = rdy;
    HSYNC_Sig = hs; VSYNC_Sig = 1'b1; Move_En = 1'($urandom_range(0, 1));
    e0 = exp_rgb(0, c, r, rdy);
    e1 = exp_rgb(1, c, r, rdy);
    @(posedge vga_clk); #1;
    check({tag, "/rgb0"}, 16'(rgb0), 16'(e0));
    check({tag, "/rgb1"}, 16'(rgb1), 16'(e1));
    check({tag, "/hsync"}, 16'(hs0), 16'(hs));
    check({tag, "/vsync"}, 16'(vs0), 16'd1);
  endtask

  // VSYNC falls with Move_En=en; Move_En is inverted while VSYNC stays low to show it is ignored.
  task automatic tick(input bit en, input int hold);
    VSYNC_Sig = 1'b0; Move_En = en; Ready_Sig = 1'b0; HSYNC_Sig = 1'b1;
    @(posedge vga_clk); #1;
    if (en) begin model_tick(0); model_tick(1); end
    check("tick/vsync_out", 16'(vs0), 16'd0);
    check("tick/blank_rgb", 16'(rgb0), 16'd0);
    Move_En = ~en;
    repeat (hold) @(posedge vga_clk);
    #1;
  endtask

  task automatic probe_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      pix(mx[i], my[i], 1'b1, {tag, "/tl"});
      pix(mx[i] + SIZE - 1, my[i] + SIZE - 1, 1'b1, {tag, "/br"});
      if (mx[i] + SIZE < H) pix(mx[i] + SIZE, my[i], 1'b1, {tag, "/right_out"});
      if (mx[i] > 0) pix(mx[i] - 1, my[i] + SIZE / 2, 1'b1, {tag, "/left_out"});
      if (my[i] + SIZE < V) pix(mx[i], my[i] + SIZE, 1'b1, {tag, "/below_out"});
    end
    pix($urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'($urandom_range(0, 1)), {tag, "/rand"});
    pix(H - 1, $urandom_range(0, V - 1), 1'b1, {tag, "/border"});
  endtask

  initial begin
    model_reset();
    // Reset with sync inputs low: outputs must still show idle syncs and black.
    rst_n = 1'b0; Move_En = 1'b1; HSYNC_Sig = 1'b0; VSYNC_Sig = 1'b0; Ready_Sig = 1'b1;
    Column_Addr_Sig = 11'd100; Row_Addr_Sig = 11'd50;
    repeat (2) @(posedge vga_clk);
    #1;
    check("reset/rgb0", 16'(rgb0), 16'd0);
    check("reset/rgb1", 16'(rgb1), 16'd0);
    check("reset/hsync", 16'(hs0), 16'd1);
    check("reset/vsync", 16'(vs0), 16'd1);
    rst_n = 1'b1;

    // First frame scan.
    pix(100, 50, 1'b1, "f0/sprite_tl");
    pix(131, 81, 1'b1, "f0/sprite_br");
    pix(132, 50, 1'b1, "f0/past_sprite");
    pix(0, 0, 1'b1, "f0/corner");
    pix(400, 599, 1'b1, "f0/bottom");
    pix(799, 300, 1'b1, "f0/right");
    pix(100, 50, 1'b0, "f0/not_ready");
    pix(400, 300, 1'b1, "f0/background");

    // One tick then VSYNC low for four lines: a single move only.
    tick(1'b1, 4224);
    probe_all("long_hold");

    // Ticks with Move_En low leave everything frozen.
    for (int k = 0; k < 3; k++) tick(1'b0, 3);
    probe_all("frozen");

    // Long random run: wall bounces, the corner instance, and the colour wrap.
    for (int k = 0; k < 450; k++) begin
      tick(1'($urandom_range(0, 9) != 0), $urandom_range(1, 6));
      probe_all("run");
    end

    // Mid-line reset while drawing the sprite, released with VSYNC already low.
    rst_n = 1'b0; Ready_Sig = 1'b1; HSYNC_Sig = 1'b0; VSYNC_Sig = 1'b0; Move_En = 1'b1;
    Column_Addr_Sig = 11'(mx[0]); Row_Addr_Sig = 11'(my[0]);
    @(posedge vga_clk); #1;
    model_reset();
    check("mid_reset/rgb0", 16'(rgb0), 16'd0);
    check("mid_reset/rgb1", 16'(rgb1), 16'd0);
    check("mid_reset/hsync", 16'(hs0), 16'd1);
    check("mid_reset/vsync", 16'(vs0), 16'd1);
    rst_n = 1'b1; HSYNC_Sig = 1'b1;
    Column_Addr_Sig = 11'd100; Row_Addr_Sig = 11'd50;
    @(posedge vga_clk); #1;
    check("post_reset/rgb0", 16'(rgb0), 16'(exp_rgb(0, 100, 50, 1'b1)));
    check("post_reset/vsync", 16'(vs0), 16'd0);
    model_tick(0); model_tick(1);
    pix(104, 54, 1'b1, "post_reset/moved");
    pix(103, 54, 1'b1, "post_reset/left_of");
    probe_all("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
